fb_pingpong_ctrl: RTL and testbench
===================================

Name: fb_pingpong_ctrl

Overview:
- Double-buffer (ping-pong) controller for the 640x480 RGB565 frame store.
- A pixel producer fills the back bank while the LCD read path streams the front bank over the valid/ready pixel interface.
- Banks swap only on a reader frame boundary. If no new frame is ready, the front frame repeats.
- The block owns all bank-select, address and frame-position sequencing. The two storage banks sit outside it, behind the mem_* ports.

Parameters:
- H_ACT, 640, active pixels per line
- V_ACT, 480, active lines per frame
- DW, 16, pixel width (RGB565)
- AW, 19, bank address width; must satisfy 2^AW >= H_ACT*V_ACT

Ports:
- rd_clk  in  1  single clock for the whole block
- rst_n  in  1  reset, asynchronous assert, active-low
- wr_valid  in  1  producer pixel valid
- wr_ready  out  1  producer may transfer
- wr_data  in  DW  producer pixel
- wr_sof  in  1  marks the first pixel of a producer frame (qualified by wr_valid)
- mem_wr_en  out  1  bank write strobe
- mem_wr_bank  out  1  bank being written
- mem_wr_addr  out  AW  write address
- mem_wr_data  out  DW  write data
- mem_rd_bank  out  1  bank being read
- mem_rd_addr  out  AW  read address
- mem_rd_data  in  DW  read data, combinational from mem_rd_bank/mem_rd_addr
- pix_valid  out  1  pixel available to the LCD path
- pix_ready  in  1  LCD path accepts the pixel
- pix_data  out  DW  pixel, equal to mem_rd_data
- pix_sof  out  1  current pixel is (0,0)
- pix_eol  out  1  current pixel is the last pixel of its line
- swap_pulse  out  1  one-cycle pulse when the front bank changes
- repeat_pulse  out  1  one-cycle pulse when a front frame is replayed

Behaviour:
- Reset (rst_n low, asynchronous):
  - front=0, front_valid=0, back_full=0.
  - wr_addr=0, rd_addr=0, h_cnt=0, v_cnt=0.
  - pix_valid=0, wr_ready=1, all pulses 0.
- Transfers:
  - Write transfer: wr_valid && wr_ready.
  - Read transfer: pix_valid && pix_ready.
- Write side:
  - wr_ready = ~back_full.
  - mem_wr_en = write transfer, mem_wr_bank = ~front, mem_wr_addr = wr_addr, mem_wr_data = wr_data; all combinational.
  - wr_sof on a transfer forces that pixel to address 0 and discards any partial frame. wr_addr becomes 1.
  - On a transfer at H_ACT*V_ACT-1: wr_addr wraps to 0 and back_full is set next cycle.
  - wr_sof asserted mid-frame with no transfer: no effect.
- Read side:
  - pix_valid = front_valid (registered).
  - mem_rd_bank = front, mem_rd_addr = rd_addr, pix_data = mem_rd_data. Zero added read latency.
  - pix_sof = front_valid && rd_addr==0.
  - pix_eol = front_valid && h_cnt==H_ACT-1.
  - Each read transfer advances rd_addr and h_cnt. h_cnt wraps at H_ACT-1 and increments v_cnt. v_cnt wraps at V_ACT-1.
  - pix_valid is never withdrawn without a transfer.
- Frame end (read transfer at rd_addr==H_ACT*V_ACT-1): rd_addr, h_cnt and v_cnt all wrap to 0, then:
  - If back_full: front<=~front, back_full<=0, swap_pulse=1.
  - Otherwise: front is unchanged and repeat_pulse=1.
- Promotion (the only swap outside a frame end): if front_valid==0 && back_full, then the next cycle front<=~front, front_valid<=1, back_full<=0, swap_pulse=1.
- Same-cycle events:
  - Writer completes a frame in the same cycle as the reader's frame end: back_full is still 0 that cycle, so the frame repeats. The swap occurs at the following frame end.
  - A swap clears back_full, so wr_ready rises the cycle after the swap. The writer then fills the old front bank from address 0.
- Reset mid-operation: all state returns to reset values immediately and in-flight frames are discarded.
- Bank contents are not touched by reset.

Decomposition:
- Shared package fb_pkg holds:
  - H_ACT, V_ACT, DW, AW
  - FRAME_PIX = H_ACT*V_ACT
  - the pixel typedef
- One sub-module, fb_pos_counter: address, h_cnt and v_cnt wrapping counter plus sof/eol/last flags. Instantiated once each for the write and read sides.

Test Plan:
- Use H_ACT=4, V_ACT=3 throughout.
- Reset, then pix_ready=1 with no writes -> pix_valid stays 0 and wr_ready=1 for 50 cycles.
- Write 12 pixels 1..12 with wr_sof on the first -> mem_wr_bank=1 for all of them. back_full is set, then swap_pulse fires one cycle later and front=1. pix_data streams 1..12 with pix_sof on 1 and pix_eol on 4, 8 and 12.
- No second frame written, reader keeps pix_ready=1 -> repeat_pulse at each frame end, and 1..12 replays unchanged.
- Second frame 101..112 written mid-stream -> wr_ready drops after 112. The swap happens only after the reader accepts pixel 12, and the next pixel is 101.
- Writer sends wr_sof at wr_addr=5 -> that pixel lands at address 0, and the frame completes 12 transfers later.
- Writer's last pixel coincides with the reader's frame end -> repeat_pulse that cycle, and the swap lands at the next frame end.
- Assert rst_n low mid-frame with pix_ready toggling -> pix_valid=0 immediately. After release the block behaves exactly as after the initial reset.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared constants and types for the ping-pong frame-buffer controller.
// Holds the default frame geometry, pixel width and bank address width.
// Also provides a counter-width helper that the position counters use.
package fb_pkg;

    localparam int H_ACT     = 640;
    localparam int V_ACT     = 480;
    localparam int DW        = 16;
    localparam int AW        = 19;
    localparam int FRAME_PIX = H_ACT * V_ACT;

    typedef logic [DW-1:0] pixel_t;

    // Width of a counter that runs 0..n-1, with a minimum of one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fb_pos_counter.sv
// Frame position counter: linear address plus line/column counters, with frame-start, end-of-line and last-pixel flags.
// Latency: flags and address are combinational from the current position; the position advances on the clock edge that sees adv.
// Backpressure: holds its position while adv is low; restart shows position 0 this cycle and, with adv, moves to position 1.
// Ports: clk/rst_n; adv steps the position; restart forces the current position to 0;
//        addr/sof/eol/last describe the current (restart-adjusted) position.
module fb_pos_counter
    import fb_pkg::*;
#(
    parameter int H_ACT = 640,
    parameter int V_ACT = 480,
    parameter int AW    = 19
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          adv,
    input  logic          restart,
    output logic [AW-1:0] addr,
    output logic          sof,
    output logic          eol,
    output logic          last
);

    localparam int HW = cnt_w(H_ACT);
    localparam int VW = cnt_w(V_ACT);
    localparam logic [AW-1:0] LAST_ADDR = AW'(H_ACT * V_ACT - 1);
    localparam logic [HW-1:0] LAST_H    = HW'(H_ACT - 1);

    logic [AW-1:0] addr_q;
    logic [HW-1:0] h_q;
    logic [VW-1:0] v_q;

    logic [HW-1:0] h_cur;
    logic [VW-1:0] v_cur;

    logic [AW-1:0] addr_n;
    logic [HW-1:0] h_n;
    logic [VW-1:0] v_n;

    // A restart re-bases the current pixel at (0,0) so it is written to address 0.
    assign addr  = restart ? '0 : addr_q;
    assign h_cur = restart ? '0 : h_q;
    assign v_cur = restart ? '0 : v_q;

    assign sof  = (addr == '0);
    assign eol  = (h_cur == LAST_H);
    assign last = (addr == LAST_ADDR);

    always_comb begin
        addr_n = addr + AW'(1);
        h_n    = h_cur + HW'(1);
        v_n    = v_cur;
        if (last) begin
            addr_n = '0;
            h_n    = '0;
            v_n    = '0;
        end else if (eol) begin
            h_n = '0;
            v_n = v_cur + VW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            h_q    <= '0;
            v_q    <= '0;
        end else if (adv) begin
            addr_q <= addr_n;
            h_q    <= h_n;
            v_q    <= v_n;
        end
    end

endmodule

// File: rtl/fb_pingpong_ctrl.sv
// Ping-pong frame-buffer controller: producer fills the back bank while the LCD path streams the front bank.
// Latency: zero added read latency (pix_data is the combinational bank read); bank swaps and pulses are registered, one cycle after the deciding event.
// Backpressure: wr_ready drops while a finished back frame waits for a swap; pix_valid holds until the LCD path takes each pixel.
// Ports: wr_* producer pixel stream; mem_wr_*/mem_rd_* drive the two external banks (read is combinational);
//        pix_* LCD pixel stream with frame/line markers; swap_pulse/repeat_pulse report frame-boundary decisions.
module fb_pingpong_ctrl
    import fb_pkg::*;
#(
    parameter int H_ACT = 640,
    parameter int V_ACT = 480,
    parameter int DW    = 16,
    parameter int AW    = 19
) (
    input  logic          rd_clk,
    input  logic          rst_n,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_sof,
    output logic          mem_wr_en,
    output logic          mem_wr_bank,
    output logic [AW-1:0] mem_wr_addr,
    output logic [DW-1:0] mem_wr_data,
    output logic          mem_rd_bank,
    output logic [AW-1:0] mem_rd_addr,
    input  logic [DW-1:0] mem_rd_data,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic [DW-1:0] pix_data,
    output logic          pix_sof,
    output logic          pix_eol,
    output logic          swap_pulse,
    output logic          repeat_pulse
);

    logic front;
    logic front_valid;
    logic back_full;

    logic          wr_xfer;
    logic          rd_xfer;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic          wr_last;
    logic          rd_last;
    logic          rd_sof;
    logic          rd_eol;
    logic          wr_unused_sof;
    logic          wr_unused_eol;
    logic          wr_done;
    logic          rd_frame_end;

    assign wr_xfer = wr_valid && wr_ready;
    assign rd_xfer = pix_valid && pix_ready;

    // Write side: wr_sof on a valid pixel restarts the frame at address 0.
    fb_pos_counter #(.H_ACT(H_ACT), .V_ACT(V_ACT), .AW(AW)) u_wr_pos (
        .clk     (rd_clk),
        .rst_n   (rst_n),
        .adv     (wr_xfer),
        .restart (wr_valid && wr_sof),
        .addr    (wr_addr),
        .sof     (wr_unused_sof),
        .eol     (wr_unused_eol),
        .last    (wr_last)
    );

    fb_pos_counter #(.H_ACT(H_ACT), .V_ACT(V_ACT), .AW(AW)) u_rd_pos (
        .clk     (rd_clk),
        .rst_n   (rst_n),
        .adv     (rd_xfer),
        .restart (1'b0),
        .addr    (rd_addr),
        .sof     (rd_sof),
        .eol     (rd_eol),
        .last    (rd_last)
    );

    assign wr_ready    = ~back_full;
    assign mem_wr_en   = wr_xfer;
    assign mem_wr_bank = ~front;
    assign mem_wr_addr = wr_addr;
    assign mem_wr_data = wr_data;

    assign pix_valid   = front_valid;
    assign mem_rd_bank = front;
    assign mem_rd_addr = rd_addr;
    assign pix_data    = mem_rd_data;
    assign pix_sof     = front_valid && rd_sof;
    assign pix_eol     = front_valid && rd_eol;

    assign wr_done      = wr_xfer && wr_last;
    assign rd_frame_end = rd_xfer && rd_last;

    // Bank ownership. back_full cannot be set while it is already set
    // (wr_ready is low), so completion never collides with a swap clearing it.
    // A frame finishing in the same cycle as the reader's frame end is not
    // yet visible in back_full, so that boundary replays the front frame.
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            front        <= 1'b0;
            front_valid  <= 1'b0;
            back_full    <= 1'b0;
            swap_pulse   <= 1'b0;
            repeat_pulse <= 1'b0;
        end else begin
            swap_pulse   <= 1'b0;
            repeat_pulse <= 1'b0;
            if (wr_done) begin
                back_full <= 1'b1;
            end
            if (!front_valid && back_full) begin
                // First frame after reset: promote without waiting for a boundary.
                front       <= ~front;
                front_valid <= 1'b1;
                back_full   <= 1'b0;
                swap_pulse  <= 1'b1;
            end else if (rd_frame_end) begin
                if (back_full) begin
                    front      <= ~front;
                    back_full  <= 1'b0;
                    swap_pulse <= 1'b1;
                end else begin
                    repeat_pulse <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fb_pingpong_ctrl.sv
// Directed bench for fb_pingpong_ctrl on a 4x3 frame with a behavioural two-bank memory.
// Each scenario task drives stimulus and checks hand-computed expectations inline.
// Inputs change and outputs are sampled 1-2 time units after the rising edge.
module tb_fb_pingpong_ctrl;
    import fb_pkg::*;

    localparam int TH  = 4;
    localparam int TV  = 3;
    localparam int TAW = 4;

    logic           rd_clk;
    logic           rst_n;
    logic           wr_valid;
    logic           wr_ready;
    logic [15:0]    wr_data;
    logic           wr_sof;
    logic           mem_wr_en;
    logic           mem_wr_bank;
    logic [TAW-1:0] mem_wr_addr;
    logic [15:0]    mem_wr_data;
    logic           mem_rd_bank;
    logic [TAW-1:0] mem_rd_addr;
    logic [15:0]    mem_rd_data;
    logic           pix_valid;
    logic           pix_ready;
    logic [15:0]    pix_data;
    logic           pix_sof;
    logic           pix_eol;
    logic           swap_pulse;
    logic           repeat_pulse;

    int vec_cnt = 0;
    int err_cnt = 0;

    pixel_t bank0 [16];
    pixel_t bank1 [16];

    fb_pingpong_ctrl #(.H_ACT(TH), .V_ACT(TV), .DW(16), .AW(TAW)) dut (
        .rd_clk       (rd_clk),
        .rst_n        (rst_n),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_data      (wr_data),
        .wr_sof       (wr_sof),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_bank  (mem_wr_bank),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_rd_bank  (mem_rd_bank),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_data  (mem_rd_data),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .pix_data     (pix_data),
        .pix_sof      (pix_sof),
        .pix_eol      (pix_eol),
        .swap_pulse   (swap_pulse),
        .repeat_pulse (repeat_pulse)
    );

    always @(posedge rd_clk) begin
        if (mem_wr_en) begin
            if (mem_wr_bank) bank1[mem_wr_addr] <= mem_wr_data;
            else             bank0[mem_wr_addr] <= mem_wr_data;
        end
    end
    assign mem_rd_data = mem_rd_bank ? bank1[mem_rd_addr] : bank0[mem_rd_addr];

    initial rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc;
        @(posedge rd_clk);
        #1;
    endtask

    // One producer transfer, checking the write-port outputs it creates.
    task automatic write_px(input int d, input logic sof, input int exp_addr,
                            input logic exp_bank, input string tag);
        wr_valid = 1'b1;
        wr_data  = 16'(d);
        wr_sof   = sof;
        #1;
        vec_cnt++;
        if (mem_wr_en !== 1'b1 || wr_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL %s_wr_en d=%0d: got en=%b ready=%b want 1/1", tag, d, mem_wr_en, wr_ready);
        end
        vec_cnt++;
        if (mem_wr_addr !== TAW'(exp_addr) || mem_wr_bank !== exp_bank || mem_wr_data !== 16'(d)) begin
            err_cnt++;
            $display("FAIL %s_wr_port d=%0d: got addr=%0d bank=%b data=%0d want addr=%0d bank=%b data=%0d",
                     tag, d, mem_wr_addr, mem_wr_bank, mem_wr_data, exp_addr, exp_bank, d);
        end
        cyc();
        wr_valid = 1'b0;
        wr_sof   = 1'b0;
    endtask

    // Stream one whole frame starting at (0,0), checking data and markers.
    task automatic expect_frame(input int base, input string tag);
        pix_ready = 1'b1;
        for (int i = 0; i < TH * TV; i++) begin
            #1;
            vec_cnt++;
            if (pix_valid !== 1'b1 || pix_data !== 16'(base + i)) begin
                err_cnt++;
                $display("FAIL %s_pix[%0d]: got valid=%b data=%0d want valid=1 data=%0d",
                         tag, i, pix_valid, pix_data, base + i);
            end
            vec_cnt++;
            if (pix_sof !== (i == 0) || pix_eol !== ((i % TH) == TH - 1)) begin
                err_cnt++;
                $display("FAIL %s_mark[%0d]: got sof=%b eol=%b want sof=%b eol=%b",
                         tag, i, pix_sof, pix_eol, (i == 0), ((i % TH) == TH - 1));
            end
            cyc();
        end
    endtask

    // After the last write of the first frame: back_full then promotion.
    task automatic promote_check(input int base, input string tag);
        vec_cnt++;
        if (wr_ready !== 1'b0 || pix_valid !== 1'b0 || swap_pulse !== 1'b0) begin
            err_cnt++;
            $display("FAIL %s_full: got ready=%b valid=%b swap=%b want 0/0/0", tag, wr_ready, pix_valid, swap_pulse);
        end
        cyc();
        vec_cnt++;
        if (swap_pulse !== 1'b1 || pix_valid !== 1'b1 || mem_rd_bank !== 1'b1 || wr_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL %s_promote: got swap=%b valid=%b bank=%b ready=%b want 1/1/1/1",
                     tag, swap_pulse, pix_valid, mem_rd_bank, wr_ready);
        end
        vec_cnt++;
        if (pix_data !== 16'(base)) begin
            err_cnt++;
            $display("FAIL %s_first: got %0d want %0d", tag, pix_data, base);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; wr_valid = 1'b0; wr_sof = 1'b0; wr_data = '0; pix_ready = 1'b0;
        #3;
        vec_cnt++;
        if (pix_valid !== 1'b0 || wr_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL reset_hs: got valid=%b ready=%b want 0/1", pix_valid, wr_ready);
        end
        vec_cnt++;
        if (swap_pulse !== 1'b0 || repeat_pulse !== 1'b0 || pix_sof !== 1'b0 || pix_eol !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_flags: got swap=%b rep=%b sof=%b eol=%b want 0", swap_pulse, repeat_pulse, pix_sof, pix_eol);
        end
        vec_cnt++;
        if (mem_wr_bank !== 1'b1 || mem_rd_bank !== 1'b0 || mem_rd_addr !== '0 || mem_wr_addr !== '0 || mem_wr_en !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_mem: got wbank=%b rbank=%b raddr=%0d waddr=%0d en=%b want 1/0/0/0/0",
                     mem_wr_bank, mem_rd_bank, mem_rd_addr, mem_wr_addr, mem_wr_en);
        end
        repeat (2) @(posedge rd_clk);
        #4 rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_idle;
        pix_ready = 1'b1;
        for (int c = 0; c < 50; c++) begin
            vec_cnt++;
            if (pix_valid !== 1'b0 || wr_ready !== 1'b1) begin
                err_cnt++;
                $display("FAIL idle[%0d]: got valid=%b ready=%b want 0/1", c, pix_valid, wr_ready);
            end
            cyc();
        end
    endtask

    task automatic test_first_frame;
        for (int i = 0; i < TH * TV; i++) write_px(1 + i, (i == 0), i, 1'b1, "f1");
        promote_check(1, "f1");
        expect_frame(1, "f1");
    endtask

    task automatic test_repeat;
        for (int r = 0; r < 2; r++) begin
            vec_cnt++;
            if (repeat_pulse !== 1'b1 || swap_pulse !== 1'b0 || mem_rd_bank !== 1'b1) begin
                err_cnt++;
                $display("FAIL repeat[%0d]: got rep=%b swap=%b bank=%b want 1/0/1", r, repeat_pulse, swap_pulse, mem_rd_bank);
            end
            expect_frame(1, "rep");
        end
    endtask

    // Second frame written while the reader stalls then streams the replay.
    task automatic test_second_frame;
        for (int c = 0; c < 15; c++) begin
            wr_valid  = (c < 12);
            wr_data   = 16'(101 + c);
            wr_sof    = (c == 0);
            pix_ready = (c >= 3);
            #1;
            if (c < 12) begin
                vec_cnt++;
                if (mem_wr_en !== 1'b1 || mem_wr_bank !== 1'b0 || mem_wr_addr !== TAW'(c)) begin
                    err_cnt++;
                    $display("FAIL f2_wr[%0d]: got en=%b bank=%b addr=%0d want 1/0/%0d", c, mem_wr_en, mem_wr_bank, mem_wr_addr, c);
                end
            end
            if (c == 12) begin
                vec_cnt++;
                if (wr_ready !== 1'b0) begin
                    err_cnt++;
                    $display("FAIL f2_ready_drop: got %b want 0", wr_ready);
                end
            end
            if (c >= 3) begin
                vec_cnt++;
                if (pix_data !== 16'(c - 2) || pix_valid !== 1'b1) begin
                    err_cnt++;
                    $display("FAIL f2_rd[%0d]: got valid=%b data=%0d want 1/%0d", c, pix_valid, pix_data, c - 2);
                end
            end
            cyc();
        end
        wr_valid = 1'b0; wr_sof = 1'b0;
        vec_cnt++;
        if (swap_pulse !== 1'b1 || repeat_pulse !== 1'b0 || mem_rd_bank !== 1'b0 || wr_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL f2_swap: got swap=%b rep=%b bank=%b ready=%b want 1/0/0/1", swap_pulse, repeat_pulse, mem_rd_bank, wr_ready);
        end
        vec_cnt++;
        if (pix_data !== 16'd101 || pix_sof !== 1'b1) begin
            err_cnt++;
            $display("FAIL f2_next: got data=%0d sof=%b want 101/1", pix_data, pix_sof);
        end
    endtask

    // Restart via wr_sof mid-frame; a wr_sof with no valid must be ignored.
    task automatic test_midframe_sof;
        pix_ready = 1'b0;
        write_px(201, 1'b1, 0, 1'b1, "ms");
        write_px(202, 1'b0, 1, 1'b1, "ms");
        write_px(203, 1'b0, 2, 1'b1, "ms");
        wr_sof = 1'b1;
        cyc();
        wr_sof = 1'b0;
        write_px(204, 1'b0, 3, 1'b1, "ms");
        write_px(205, 1'b0, 4, 1'b1, "ms");
        write_px(300, 1'b1, 0, 1'b1, "ms");
        for (int i = 1; i < TH * TV; i++) write_px(300 + i, 1'b0, i, 1'b1, "ms");
        vec_cnt++;
        if (wr_ready !== 1'b0 || pix_valid !== 1'b1 || pix_data !== 16'd101) begin
            err_cnt++;
            $display("FAIL ms_full: got ready=%b valid=%b data=%0d want 0/1/101", wr_ready, pix_valid, pix_data);
        end
        expect_frame(101, "ms101");
        vec_cnt++;
        if (swap_pulse !== 1'b1 || mem_rd_bank !== 1'b1 || pix_data !== 16'd300) begin
            err_cnt++;
            $display("FAIL ms_swap: got swap=%b bank=%b data=%0d want 1/1/300", swap_pulse, mem_rd_bank, pix_data);
        end
        expect_frame(300, "ms300");
        vec_cnt++;
        if (repeat_pulse !== 1'b1 || swap_pulse !== 1'b0) begin
            err_cnt++;
            $display("FAIL ms_repeat: got rep=%b swap=%b want 1/0", repeat_pulse, swap_pulse);
        end
    endtask

    // Writer's last pixel lands on the reader's frame end.
    task automatic test_coincide;
        pix_ready = 1'b1;
        for (int c = 0; c < TH * TV; c++) begin
            wr_valid = 1'b1;
            wr_data  = 16'(400 + c);
            wr_sof   = (c == 0);
            #1;
            vec_cnt++;
            if (pix_data !== 16'(300 + c) || mem_wr_bank !== 1'b0 || mem_wr_addr !== TAW'(c)) begin
                err_cnt++;
                $display("FAIL co[%0d]: got data=%0d wbank=%b waddr=%0d want %0d/0/%0d",
                         c, pix_data, mem_wr_bank, mem_wr_addr, 300 + c, c);
            end
            cyc();
        end
        wr_valid = 1'b0; wr_sof = 1'b0;
        vec_cnt++;
        if (repeat_pulse !== 1'b1 || swap_pulse !== 1'b0 || mem_rd_bank !== 1'b1 || pix_data !== 16'd300 || wr_ready !== 1'b0) begin
            err_cnt++;
            $display("FAIL co_repeat: got rep=%b swap=%b bank=%b data=%0d ready=%b want 1/0/1/300/0",
                     repeat_pulse, swap_pulse, mem_rd_bank, pix_data, wr_ready);
        end
        expect_frame(300, "co");
        vec_cnt++;
        if (swap_pulse !== 1'b1 || mem_rd_bank !== 1'b0 || pix_data !== 16'd400 || wr_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL co_swap: got swap=%b bank=%b data=%0d ready=%b want 1/0/400/1",
                     swap_pulse, mem_rd_bank, pix_data, wr_ready);
        end
    endtask

    task automatic test_reset_mid;
        for (int c = 0; c < 6; c++) begin
            pix_ready = c[0];
            wr_valid  = 1'b1;
            wr_data   = 16'(600 + c);
            wr_sof    = (c == 0);
            cyc();
        end
        wr_valid = 1'b0; wr_sof = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        vec_cnt++;
        if (pix_valid !== 1'b0 || wr_ready !== 1'b1 || pix_sof !== 1'b0) begin
            err_cnt++;
            $display("FAIL rm_async: got valid=%b ready=%b sof=%b want 0/1/0", pix_valid, wr_ready, pix_sof);
        end
        vec_cnt++;
        if (mem_rd_addr !== '0 || mem_wr_addr !== '0 || mem_rd_bank !== 1'b0 || swap_pulse !== 1'b0 || repeat_pulse !== 1'b0) begin
            err_cnt++;
            $display("FAIL rm_state: got raddr=%0d waddr=%0d rbank=%b swap=%b rep=%b want 0/0/0/0/0",
                     mem_rd_addr, mem_wr_addr, mem_rd_bank, swap_pulse, repeat_pulse);
        end
        repeat (2) @(posedge rd_clk);
        #4 rst_n = 1'b1;
        cyc();
        for (int c = 0; c < 10; c++) begin
            pix_ready = c[0];
            #1;
            vec_cnt++;
            if (pix_valid !== 1'b0 || wr_ready !== 1'b1) begin
                err_cnt++;
                $display("FAIL rm_idle[%0d]: got valid=%b ready=%b want 0/1", c, pix_valid, wr_ready);
            end
            cyc();
        end
        pix_ready = 1'b1;
        for (int i = 0; i < TH * TV; i++) write_px(501 + i, (i == 0), i, 1'b1, "rm");
        promote_check(501, "rm");
        expect_frame(501, "rm");
    endtask

    initial begin
        test_reset();
        test_idle();
        test_first_frame();
        test_repeat();
        test_second_frame();
        test_midframe_sof();
        test_coincide();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
